// File: rtl/output_sig.sv
// Output pin driver: buffers codes from core logic in a small FIFO and shows each
// on the registered output for HOLD_CYCLES, separated by GAP_CYCLES of IDLE_VAL.
module output_sig #(
   parameter int unsigned   WIDTH       = 4,
   parameter int unsigned   DEPTH       = 4,
   parameter int unsigned   HOLD_CYCLES = 3,
   parameter int unsigned   GAP_CYCLES  = 1,
   parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out,
   output logic                       out_active,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    mem_q [DEPTH];
   logic [AW-1:0]       wptr_q, rptr_q;
   logic [CW-1:0]       count_q, count_d;
   logic [WIDTH-1:0]    out_q, out_d;
   logic                act_q, act_d;
   logic [HW-1:0]       hcnt_q, hcnt_d;
   logic [GW-1:0]       gcnt_q, gcnt_d;
   logic                push, pop;

   assign in_ready   = !rst && (count_q != CW'(DEPTH));
   assign push       = in_valid && in_ready;
   assign out        = out_q;
   assign out_active = act_q;
   assign fifo_count = count_q;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      act_d   = act_q;
      hcnt_d  = hcnt_q;
      gcnt_d  = gcnt_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            out_d = IDLE_VAL;
            act_d = 1'b0;
            if (count_q != '0) begin
               pop     = 1'b1;
               out_d   = mem_q[rptr_q];
               act_d   = 1'b1;
               hcnt_d  = HW'(HOLD_CYCLES - 1);
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            if (hcnt_q != '0) begin
               hcnt_d = hcnt_q - HW'(1);
            end else if (GAP_CYCLES > 0) begin
               out_d   = IDLE_VAL;
               act_d   = 1'b0;
               gcnt_d  = GW'(GAP_LOAD);
               state_d = S_GAP;
            end else if (count_q != '0) begin
               pop    = 1'b1;
               out_d  = mem_q[rptr_q];
               hcnt_d = HW'(HOLD_CYCLES - 1);
            end else begin
               out_d   = IDLE_VAL;
               act_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            if (gcnt_q != '0) begin
               gcnt_d = gcnt_q - GW'(1);
            end else if (count_q != '0) begin
               pop     = 1'b1;
               out_d   = mem_q[rptr_q];
               act_d   = 1'b1;
               hcnt_d  = HW'(HOLD_CYCLES - 1);
               state_d = S_SHOW;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         out_q   <= IDLE_VAL;
         act_q   <= 1'b0;
         hcnt_q  <= '0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         out_q   <= out_d;
         act_q   <= act_d;
         hcnt_q  <= hcnt_d;
         gcnt_q  <= gcnt_d;
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
      end
   end

   // Storage needs no reset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= in;
   end

endmodule

// File: tb/tb_output_sig.sv
// Directed self-checking bench for output_sig: default config plus a no-gap instance.
module tb_output_sig;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a_in = '0, b_in = '0;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic       a_ready, b_ready;
   logic [3:0] a_out, b_out;
   logic       a_act, b_act;
   logic [2:0] a_cnt, b_cnt;

   int tests = 0;
   int fails = 0;

   output_sig u_a (
      .clk(clk), .rst(rst), .in(a_in), .in_valid(a_valid), .in_ready(a_ready),
      .out(a_out), .out_active(a_act), .fifo_count(a_cnt)
   );

   output_sig #(.HOLD_CYCLES(2), .GAP_CYCLES(0)) u_b (
      .clk(clk), .rst(rst), .in(b_in), .in_valid(b_valid), .in_ready(b_ready),
      .out(b_out), .out_active(b_act), .fifo_count(b_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [3:0] codes [10] = '{4'h3, 4'hC, 4'h5, 4'hA, 4'hE, 4'h1, 4'h9, 4'h6, 4'hB, 4'hD};

   initial begin
      int idx;
      int seen;
      logic prev_act;
      logic acc;

      // reset
      step(); step();
      chk("rst_out", a_out, 4'h0);
      chk("rst_act", a_act, 1'b0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_ready", a_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", a_ready, 1'b1);

      // single code
      a_in = 4'hA; a_valid = 1'b1;
      step();                                  // edge 0
      a_valid = 1'b0;
      chk("single_cnt0", a_cnt, 1);
      chk("single_out0", a_out, 4'h0);
      for (int e = 1; e <= 3; e++) begin
         step();
         chk("single_show", a_out, 4'hA);
         chk("single_act", a_act, 1'b1);
         chk("single_cnt", a_cnt, 0);
      end
      step();                                  // edge 4: gap
      chk("single_gap_out", a_out, 4'h0);
      chk("single_gap_act", a_act, 1'b0);
      step(); step();
      chk("single_idle_out", a_out, 4'h0);
      chk("single_idle_act", a_act, 1'b0);

      // fill / backpressure
      a_in = 4'h1; a_valid = 1'b1;
      step();                                  // edge 0
      chk("fill_cnt_e0", a_cnt, 1);
      a_in = 4'h2;
      step();                                  // edge 1
      chk("fill_out_e1", a_out, 4'h1);
      chk("fill_cnt_e1", a_cnt, 1);
      a_in = 4'h3;
      step();                                  // edge 2
      chk("fill_cnt_e2", a_cnt, 2);
      a_in = 4'h4;
      step();                                  // edge 3
      chk("fill_cnt_e3", a_cnt, 3);
      a_in = 4'h5;
      step();                                  // edge 4
      chk("fill_cnt_e4", a_cnt, 4);
      chk("fill_ready_e4", a_ready, 1'b0);
      step();                                  // edge 5: no push, pop code 2
      chk("fill_out_e5", a_out, 4'h2);
      chk("fill_cnt_e5", a_cnt, 3);
      chk("fill_ready_e5", a_ready, 1'b1);
      a_in = 4'h6;
      step();                                  // edge 6: push 6
      chk("fill_cnt_e6", a_cnt, 4);
      a_valid = 1'b0;
      for (int e = 7; e <= 26; e++) begin
         int k, r;
         step();
         k = (e - 1) / 4 + 1;
         r = (e - 1) % 4;
         if (k <= 6 && r < 3) begin
            chk("fill_seq_out", a_out, k);
            chk("fill_seq_act", a_act, 1'b1);
         end else begin
            chk("fill_seq_out", a_out, 4'h0);
            chk("fill_seq_act", a_act, 1'b0);
         end
      end
      chk("fill_cnt_end", a_cnt, 0);

      // IDLE_VAL-valued code
      a_in = 4'h0; a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         step();
         chk("zero_out", a_out, 4'h0);
         chk("zero_act", a_act, 1'b1);
      end
      step();
      chk("zero_gap_act", a_act, 1'b0);
      step(); step();

      // reset mid-SHOW
      a_in = 4'hF; a_valid = 1'b1;
      step();                                  // edge 0
      a_in = 4'h7;
      step();                                  // edge 1: out=F, 7 buffered
      a_valid = 1'b0;
      chk("mid_out_f", a_out, 4'hF);
      rst = 1'b1;
      #1;
      chk("mid_ready_rst", a_ready, 1'b0);
      step();
      chk("mid_out", a_out, 4'h0);
      chk("mid_act", a_act, 1'b0);
      chk("mid_cnt", a_cnt, 0);
      chk("mid_ready", a_ready, 1'b0);
      rst = 1'b0;
      for (int e = 0; e < 6; e++) begin
         step();
         chk("mid_never7_out", a_out, 4'h0);
         chk("mid_never7_act", a_act, 1'b0);
      end

      // pointer wrap with in_ready pacing
      idx = 0; seen = 0; prev_act = 1'b0;
      for (int c = 0; c < 70; c++) begin
         a_valid = (idx < 10);
         a_in = (idx < 10) ? codes[idx] : 4'h0;
         acc = a_valid && a_ready;
         step();
         if (acc) idx++;
         chk("wrap_cnt_max", a_cnt <= 3'd4, 1'b1);
         if (a_act && !prev_act) begin
            if (seen < 10) chk("wrap_code", a_out, codes[seen]);
            else chk("wrap_extra", seen, 10);
            seen++;
         end
         prev_act = a_act;
      end
      a_valid = 1'b0;
      chk("wrap_seen", seen, 10);
      chk("wrap_cnt_end", a_cnt, 0);

      // no-gap instance: HOLD=2, GAP=0
      b_in = 4'h3; b_valid = 1'b1;
      step();                                  // edge 0
      b_in = 4'h5;
      step();                                  // edge 1
      b_valid = 1'b0;
      chk("ng_out_e1", b_out, 4'h3);
      chk("ng_act_e1", b_act, 1'b1);
      step();
      chk("ng_out_e2", b_out, 4'h3);
      chk("ng_act_e2", b_act, 1'b1);
      step();
      chk("ng_out_e3", b_out, 4'h5);
      chk("ng_act_e3", b_act, 1'b1);
      step();
      chk("ng_out_e4", b_out, 4'h5);
      chk("ng_act_e4", b_act, 1'b1);
      step();
      chk("ng_out_e5", b_out, 4'h0);
      chk("ng_act_e5", b_act, 1'b0);
      chk("ng_cnt_e5", b_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
